// File: rtl/hazard_ctrl_pkg.sv
// Shared pipeline definitions for the hazard controller: action codes,
// counter widths, watchdog limit and the action-to-control decode.
package hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    ACT_RUN      = 2'd0,
    ACT_LU_STALL = 2'd1,
    ACT_WAIT     = 2'd2,
    ACT_FLUSH    = 2'd3
  } action_e;

  localparam int CNT_W  = 16;
  localparam int WAIT_W = 8;
  localparam logic [WAIT_W-1:0] WDOG_LIMIT = 8'd255;

  typedef struct packed {
    logic pc_write;
    logic ifid_write;
    logic ifid_flush;
    logic idex_flush;
    logic pipe_hold;
  } ctrl_t;

  function automatic ctrl_t ctrl_of(action_e a);
    ctrl_t c;
    c = '{pc_write: 1'b1, ifid_write: 1'b1, default: 1'b0};
    case (a)
      ACT_LU_STALL: c = '{idex_flush: 1'b1, default: 1'b0};
      ACT_WAIT:     c = '{pipe_hold: 1'b1, default: 1'b0};
      ACT_FLUSH:    c = '{pc_write: 1'b1, ifid_write: 1'b1, ifid_flush: 1'b1,
                          idex_flush: 1'b1, pipe_hold: 1'b0};
      default:      ;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline <-> hazard controller signal bundle. master = pipeline side,
// slave = hazard controller.
interface hazard_ctrl_if;
  import hazard_ctrl_pkg::*;

  logic [4:0]       rs_ID;
  logic [4:0]       rt_ID;
  logic             uses_rt_ID;
  logic [4:0]       rd_EX;
  logic             MemRead_EX;
  logic             branch_taken_EX;
  logic             mem_req_MEM;
  logic             mem_ready;

  logic             pc_write;
  logic             ifid_write;
  logic             ifid_flush;
  logic             idex_flush;
  logic             pipe_hold;
  logic [1:0]       state;
  logic [CNT_W-1:0] stall_count;
  logic [CNT_W-1:0] flush_count;
  logic             mem_timeout;

  modport master (
    output rs_ID, rt_ID, uses_rt_ID, rd_EX, MemRead_EX, branch_taken_EX,
           mem_req_MEM, mem_ready,
    input  pc_write, ifid_write, ifid_flush, idex_flush, pipe_hold, state,
           stall_count, flush_count, mem_timeout
  );

  modport slave (
    input  rs_ID, rt_ID, uses_rt_ID, rd_EX, MemRead_EX, branch_taken_EX,
           mem_req_MEM, mem_ready,
    output pc_write, ifid_write, ifid_flush, idex_flush, pipe_hold, state,
           stall_count, flush_count, mem_timeout
  );
endinterface

// File: rtl/hazard_ctrl_sat_counter.sv
// Enable-driven up counter that sticks at all-ones.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  output logic [W-1:0] count
);
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                     count <= '0;
    else if (en && count != '1)  count <= count + 1'b1;
  end
endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: zero-latency stall/flush decode plus
// registered action, event counters and a memory-wait watchdog.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
(
  input logic          clk,
  input logic          rst,
  hazard_ctrl_if.slave hz
);

  action_e          act, state_q;
  ctrl_t            ctrl;
  logic             lu_hazard;
  logic [WAIT_W-1:0] wait_cnt;
  logic             timeout_q;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  assign lu_hazard = hz.MemRead_EX && (hz.rd_EX != 5'd0) &&
                     ((hz.rd_EX == hz.rs_ID) ||
                      (hz.uses_rt_ID && (hz.rd_EX == hz.rt_ID)));

  // A branch stuck behind a memory wait resolves on the ready cycle.
  always_comb begin
    act = ACT_RUN;
    if (hz.mem_req_MEM && !hz.mem_ready) act = ACT_WAIT;
    else if (hz.branch_taken_EX)         act = ACT_FLUSH;
    else if (lu_hazard)                  act = ACT_LU_STALL;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ACT_RUN;
    else     state_q <= act;
  end

  assign ctrl          = ctrl_of(act);
  assign hz.pc_write   = ctrl.pc_write;
  assign hz.ifid_write = ctrl.ifid_write;
  assign hz.ifid_flush = ctrl.ifid_flush;
  assign hz.idex_flush = ctrl.idex_flush;
  assign hz.pipe_hold  = ctrl.pipe_hold;
  assign hz.state      = state_q;

  // Watchdog only flags; the pipeline keeps waiting regardless.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt  <= '0;
      timeout_q <= 1'b0;
    end else if (act == ACT_WAIT) begin
      if (wait_cnt == WDOG_LIMIT) timeout_q <= 1'b1;
      else                        wait_cnt  <= wait_cnt + 1'b1;
    end else begin
      wait_cnt <= '0;
    end
  end

  assign hz.mem_timeout = timeout_q;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .en    ((act == ACT_LU_STALL) || (act == ACT_WAIT)),
    .count (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .en    (act == ACT_FLUSH),
    .count (flush_cnt)
  );

  assign hz.stall_count = stall_cnt;
  assign hz.flush_count = flush_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed scenarios plus random traffic, checked
// every cycle against a behavioural model of the classification rules.
module tb_hazard_ctrl;
  import hazard_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hazard_ctrl_if hz();
  hazard_ctrl dut (.clk(clk), .rst(rst), .hz(hz));

  int n_chk = 0;
  int n_fail = 0;

  // model state
  int   m_state, m_stall, m_flush, m_run;
  logic m_to;

  function automatic int classify();
    if (hz.mem_req_MEM && !hz.mem_ready) return 2;
    if (hz.branch_taken_EX) return 3;
    if (hz.MemRead_EX && hz.rd_EX != 0 &&
        (hz.rd_EX == hz.rs_ID || (hz.uses_rt_ID && hz.rd_EX == hz.rt_ID))) return 1;
    return 0;
  endfunction

  // {pc_write, ifid_write, ifid_flush, idex_flush, pipe_hold}
  function automatic logic [4:0] exp_ctrl(int a);
    case (a)
      1: return 5'b00010;
      2: return 5'b00001;
      3: return 5'b11110;
      default: return 5'b11000;
    endcase
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_state <= 0; m_stall <= 0; m_flush <= 0; m_run <= 0; m_to <= 1'b0;
    end else begin
      m_state <= classify();
      if (classify() == 1 || classify() == 2)
        m_stall <= (m_stall < 65535) ? m_stall + 1 : m_stall;
      if (classify() == 3)
        m_flush <= (m_flush < 65535) ? m_flush + 1 : m_flush;
      if (classify() == 2) begin
        m_run <= m_run + 1;
        if (m_run + 1 >= 256) m_to <= 1'b1;
      end else begin
        m_run <= 0;
      end
    end
  end

  task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic set_in(logic [4:0] rs, logic [4:0] rt, logic urt, logic [4:0] rd,
                        logic mr, logic br, logic mreq, logic mrdy);
    hz.rs_ID = rs; hz.rt_ID = rt; hz.uses_rt_ID = urt; hz.rd_EX = rd;
    hz.MemRead_EX = mr; hz.branch_taken_EX = br;
    hz.mem_req_MEM = mreq; hz.mem_ready = mrdy;
  endtask

  task automatic nop_in();
    set_in(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  // One clock: compare everything at the falling edge, return just after rise.
  task automatic cyc();
    @(negedge clk);
    chk("ctrl", {hz.pc_write, hz.ifid_write, hz.ifid_flush, hz.idex_flush, hz.pipe_hold},
        exp_ctrl(classify()));
    chk("state", hz.state, m_state);
    chk("stall_count", hz.stall_count, m_stall);
    chk("flush_count", hz.flush_count, m_flush);
    chk("mem_timeout", hz.mem_timeout, m_to);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    set_in(5'd4, 5'd0, 1'b0, 5'd4, 1'b1, 1'b0, 1'b0, 1'b1);
    #1;
    chk("rst_comb_follow", hz.idex_flush, 1);
    cyc(); cyc();
    rst = 1'b0;
    nop_in();
  endtask

  initial begin
    nop_in();
    do_reset();
    chk("rst_state", hz.state, 0);
    chk("rst_stall", hz.stall_count, 0);
    chk("rst_flush", hz.flush_count, 0);
    chk("rst_timeout", hz.mem_timeout, 0);

    // load-use on rs, then NOP in EX
    set_in(5'd8, 5'd0, 1'b0, 5'd8, 1'b1, 1'b0, 1'b0, 1'b1);
    #1;
    chk("lu_pc_write", hz.pc_write, 0);
    chk("lu_idex_flush", hz.idex_flush, 1);
    cyc();
    chk("lu_state", hz.state, 1);
    chk("lu_stall", hz.stall_count, 1);
    nop_in(); cyc();
    chk("lu_once_state", hz.state, 0);
    chk("lu_once_stall", hz.stall_count, 1);

    // rt hazard gated by uses_rt_ID, r0 never hazards
    set_in(5'd1, 5'd9, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0, 1'b1); cyc();
    chk("rt_unused_state", hz.state, 0);
    set_in(5'd1, 5'd9, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0, 1'b1); cyc();
    chk("rt_used_state", hz.state, 1);
    chk("rt_used_stall", hz.stall_count, 2);
    nop_in(); cyc();
    set_in(5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1); cyc();
    chk("r0_state", hz.state, 0);
    chk("r0_stall", hz.stall_count, 2);

    // branch held during memory wait
    do_reset();
    for (int i = 0; i < 3; i++) begin
      set_in(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0);
      #1;
      chk("bw_pipe_hold", hz.pipe_hold, 1);
      cyc();
    end
    set_in(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1); cyc();
    chk("bw_state", hz.state, 3);
    chk("bw_stall", hz.stall_count, 3);
    chk("bw_flush", hz.flush_count, 1);

    // branch with simultaneous load-use
    set_in(5'd5, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b1);
    #1;
    chk("blu_ifid_flush", hz.ifid_flush, 1);
    cyc();
    chk("blu_stall", hz.stall_count, 3);
    chk("blu_flush", hz.flush_count, 2);
    nop_in(); cyc();

    // watchdog
    do_reset();
    set_in(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 255; i++) cyc();
    chk("wd_255_timeout", hz.mem_timeout, 0);
    cyc();
    chk("wd_256_timeout", hz.mem_timeout, 1);
    for (int i = 0; i < 44; i++) cyc();
    chk("wd_stall", hz.stall_count, 300);
    hz.mem_ready = 1'b1; cyc();
    chk("wd_sticky", hz.mem_timeout, 1);
    chk("wd_after_state", hz.state, 0);

    // async reset mid-wait clears registers and the wait run
    do_reset();
    set_in(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1); cyc();
    set_in(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 200; i++) cyc();
    rst = 1'b1;
    #1;
    chk("arst_stall", hz.stall_count, 0);
    chk("arst_flush", hz.flush_count, 0);
    chk("arst_state", hz.state, 0);
    cyc();
    rst = 1'b0;
    for (int i = 0; i < 100; i++) cyc();
    chk("arst_wd_cleared", hz.mem_timeout, 0);
    chk("arst_stall_after", hz.stall_count, 100);

    // random traffic; after a load-use stall EX holds the bubble
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      logic [4:0] rd;
      logic       mr;
      rd = 5'($urandom_range(0, 3));
      mr = ($urandom_range(0, 9) < 4);
      if (m_state == 1) begin rd = 5'd0; mr = 1'b0; end
      set_in(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom),
             rd, mr, ($urandom_range(0, 99) < 15),
             ($urandom_range(0, 9) < 3), ($urandom_range(0, 9) < 6));
      cyc();
    end

    // flush counter saturation
    do_reset();
    set_in(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 65540; i++) cyc();
    chk("sat_flush", hz.flush_count, 32'hFFFF);
    chk("sat_stall", hz.stall_count, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
